uart_rx_ctrl: RTL and testbench

Frame controller for the UART receiver. It sits around the data-sampling stage: it feeds that stage edge_cnt and dat_samp_en, and consumes its majority-voted sampled_bit. It tracks start, data, parity and stop bits, deserialises the data LSB-first, checks parity and stop, and presents a parallel byte with a one-cycle valid pulse.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_edge_bit_cnt.sv | 34 +++
 rtl/uart_rx_ctrl.sv | 107 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   PRESCALE_MIN = 8;
    localparam logic EVEN         = 1'b0;
    localparam logic ODD          = 1'b1;
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter; bit_end marks the last edge of a bit.
module uart_rx_edge_bit_cnt #(
    parameter int BW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic [5:0]    prescale,
    input  logic          bit_clr,
    input  logic          bit_inc,
    output logic [5:0]    edge_cnt,
    output logic [BW-1:0] bit_cnt,
    output logic          bit_end
);
    assign bit_end = en && (edge_cnt == prescale - 6'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            // Held at 0 while idle so the first START cycle is edge 0.
            if (!en || bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 6'd1;

            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_inc)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop tracking, LSB-first deserialisation, error pulses.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    state_t                state, next;
    logic [5:0]            fr_prescale;
    logic                  fr_par_en, fr_par_typ;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  frm_err;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_end;
    logic                  exp_par;

    assign dat_samp_en = (state != IDLE);
    assign exp_par     = (^shreg) ^ (fr_par_typ == ODD);

    uart_rx_edge_bit_cnt #(.BW(BW)) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .en       (dat_samp_en),
        .prescale (fr_prescale),
        .bit_clr  ((state == START) && bit_end),
        .bit_inc  ((state == DATA) && bit_end),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   if (!RX_IN) next = START;
            START:  if (bit_end) next = sampled_bit ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == BW'(DATA_WIDTH - 1))
                        next = fr_par_en ? PARITY : STOP;
            PARITY: if (bit_end) next = STOP;
            STOP:   if (bit_end) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fr_prescale <= 6'(PRESCALE_MIN);
            fr_par_en   <= 1'b0;
            fr_par_typ  <= EVEN;
            shreg       <= '0;
            frm_err     <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            // Frame configuration is frozen at the start edge.
            if (state == IDLE && !RX_IN) begin
                fr_prescale <= prescale;
                fr_par_en   <= PAR_EN;
                fr_par_typ  <= PAR_TYP;
            end
            if (bit_end) begin
                case (state)
                    DATA:   shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                    PARITY: if (sampled_bit != exp_par) begin
                                par_err <= 1'b1;
                                frm_err <= 1'b1;
                            end
                    STOP: begin
                        if (!sampled_bit)
                            stp_err <= 1'b1;
                        else if (!frm_err) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        frm_err <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a 3-sample majority-vote sampler model in the loop.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    int total = 0;
    int bad   = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    // Sampler model: vote three samples around mid-bit, result ready at half+2.
    logic v0 = 1'b1, v1 = 1'b1, v2 = 1'b1;
    always @(posedge CLK) begin
        if (dat_samp_en) begin
            if (edge_cnt == (prescale >> 1) - 6'd1) v0 <= RX_IN;
            if (edge_cnt == (prescale >> 1))        v1 <= RX_IN;
            if (edge_cnt == (prescale >> 1) + 6'd1) v2 <= RX_IN;
            if (edge_cnt == (prescale >> 1) + 6'd2)
                sampled_bit <= (v0 & v1) | (v0 & v2) | (v1 & v2);
        end
    end

    // Output monitor, sampled on the falling edge.
    int         cyc = 0, dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         dv_cyc = 0, st_cyc = 0, fall_cyc = 0, last_ec = 0;
    logic       dse_q = 1'b0;
    logic [7:0] dv_log [0:31];
    always @(negedge CLK) begin
        cyc   <= cyc + 1;
        dse_q <= dat_samp_en;
        if (data_valid) begin
            dv_log[dv_cnt % 32] <= P_DATA;
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
        end
        if (par_err) pe_cnt <= pe_cnt + 1;
        if (stp_err) se_cnt <= se_cnt + 1;
        if (dat_samp_en && !dse_q) st_cyc <= cyc;
        if (!dat_samp_en && dse_q) fall_cyc <= cyc;
        if (dat_samp_en) last_ec <= int'(edge_cnt);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int ps);
        RX_IN = b;
        repeat (ps) begin @(posedge CLK); #1; end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // chg_at >= 0 switches prescale to 8 after that data bit, mid-frame.
    task automatic send_frame(input logic [7:0] d, input int ps, input logic pe,
                              input logic pb, input logic sb, input int chg_at);
        send_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], ps);
            if (i == chg_at) prescale = 6'd8;
        end
        if (pe) send_bit(pb, ps);
        send_bit(sb, ps);
    endtask

    initial begin
        int dv0, pe0, se0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_pe", 32'(par_err), 32'h0);
        check("rst_se", 32'(stp_err), 32'h0);
        check("rst_dse", 32'(dat_samp_en), 32'h0);
        check("rst_ec", 32'(edge_cnt), 32'h0);
        RST = 1'b1;
        idle(4);

        // prescale 8, no parity, 0xA5
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        prescale = 6'd8; PAR_EN = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        check("a5_dv_once", 32'(dv_cnt - dv0), 32'd1);
        check("a5_pdata", 32'(P_DATA), 32'hA5);
        check("a5_latency", 32'(dv_cyc - st_cyc + 1), 32'd81);
        check("a5_no_err", 32'(pe_cnt - pe0 + se_cnt - se0), 32'd0);

        // prescale 16, even parity, 0x3C good then bad parity
        dv0 = dv_cnt; pe0 = pe_cnt;
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
        idle(4);
        check("par_ok_dv", 32'(dv_cnt - dv0), 32'd1);
        check("par_ok_pdata", 32'(P_DATA), 32'h3C);
        check("par_ok_pe", 32'(pe_cnt - pe0), 32'd0);
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
        idle(4);
        check("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
        check("par_bad_dv", 32'(dv_cnt - dv0), 32'd0);
        check("par_bad_pdata", 32'(P_DATA), 32'h3C);

        // prescale 8, 0x81 with stop bit low
        dv0 = dv_cnt; se0 = se_cnt;
        prescale = 6'd8; PAR_EN = 1'b0;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, -1);
        idle(6);
        check("stp_se", 32'(se_cnt - se0), 32'd1);
        check("stp_dv", 32'(dv_cnt - dv0), 32'd0);
        check("stp_pdata", 32'(P_DATA), 32'h3C);

        // prescale 16, 3-cycle glitch -> false start
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        prescale = 6'd16;
        send_bit(1'b0, 3);
        idle(24);
        check("glitch_len", 32'(fall_cyc - st_cyc), 32'd16);
        check("glitch_last_ec", 32'(last_ec), 32'd15);
        check("glitch_dse", 32'(dat_samp_en), 32'h0);
        check("glitch_pulses", 32'(dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0), 32'd0);

        // prescale 32, odd parity, back-to-back 0x55 / 0xAA, prescale change mid second frame
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h55, 32, 1'b1, ~(^8'h55), 1'b1, -1);
        send_frame(8'hAA, 32, 1'b1, ~(^8'hAA), 1'b1, 3);
        idle(6);
        check("b2b_dv", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_first", 32'(dv_log[dv0 % 32]), 32'h55);
        check("b2b_second", 32'(dv_log[(dv0 + 1) % 32]), 32'hAA);
        check("b2b_err", 32'(pe_cnt - pe0 + se_cnt - se0), 32'd0);

        // reset during data bit 4, then a clean 0x0F
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        prescale = 6'd8; PAR_EN = 1'b0;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
        RX_IN = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        #3 RST = 1'b0;
        #1;
        check("mid_rst_dse", 32'(dat_samp_en), 32'h0);
        check("mid_rst_ec", 32'(edge_cnt), 32'h0);
        check("mid_rst_pdata", 32'(P_DATA), 32'h0);
        check("mid_rst_flags", 32'({data_valid, par_err, stp_err}), 32'h0);
        @(posedge CLK); #1;
        idle(3);
        RST = 1'b1;
        idle(3);
        check("mid_rst_pulses", 32'(dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0), 32'd0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        check("post_rst_dv", 32'(dv_cnt - dv0), 32'd1);
        check("post_rst_pdata", 32'(P_DATA), 32'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
